// File: rtl/stack_param.sv
// -----------------------------------------------------------------------------
// stack_param -- parameterised LIFO stack with registered pop output.
//
// Pushes write at the current fill level; pops return the top entry plus a
// constant increment (POP_INC) one cycle after the pop edge. A simultaneous
// push and pop replaces the top entry while popping the old one. Overflow
// and underflow are sticky until clear or reset.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous flush of stack contents and error flags
//   i_push       push i_inpush this cycle
//   i_pop        pop the top entry this cycle
//   i_inpush     data to push (WIDTH bits)
//   o_outpop     registered popped value plus POP_INC (mod 2^WIDTH)
//   o_pop_valid  one-cycle pulse: o_outpop was updated by a successful pop
//   o_top        combinational current top entry, 0 when empty
//   o_count      registered number of valid entries (0..DEPTH)
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
//   o_overflow   sticky: push attempted while full
//   o_underflow  sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module stack_param #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 16,
  parameter int POP_INC = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_inpush,
  output logic [WIDTH-1:0]         o_outpop,
  output logic                     o_pop_valid,
  output logic [WIDTH-1:0]         o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] INC = WIDTH'(POP_INC);

  // Storage is deliberately not reset; only the fill level and flags are.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_outpop;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top_idx;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Low AW bits of count minus one; when count == DEPTH the low bits are 0
  // and the subtraction wraps to DEPTH-1, which is the correct top index.
  assign w_top_idx = r_count[AW-1:0] - AW'(1);

  // Write port: push+pop on a non-empty stack replaces the top entry; a push
  // that is not dropped (including push+pop on empty) writes at index count.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_count[AW-1:0];
    if (!i_clear && i_push) begin
      if (i_pop && !w_empty) begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_top_idx;
      end else if (!w_full) begin
        w_wr_en   = 1'b1;
      end
    end
  end

  // Writes while reset is held are harmless: count is forced to 0, so any
  // such entry is overwritten by a later push before it can become visible.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= i_inpush;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_outpop    <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      // outpop intentionally held across a clear
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      case ({i_push, i_pop})
        2'b11: begin
          if (w_empty) begin
            r_count     <= CW'(1);
            r_underflow <= 1'b1;
          end else begin
            r_outpop    <= r_mem[w_top_idx] + INC;
            r_pop_valid <= 1'b1;
          end
        end
        2'b10: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        2'b01: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_outpop    <= r_mem[w_top_idx] + INC;
            r_pop_valid <= 1'b1;
            r_count     <= r_count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_outpop    = r_outpop;
  assign o_pop_valid = r_pop_valid;
  assign o_top       = w_empty ? '0 : r_mem[w_top_idx];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_stack_param.sv
// -----------------------------------------------------------------------------
// tb_stack_param -- self-checking bench for stack_param.
//
// A queue-based LIFO model computes expected outputs for every operation;
// directed scenarios are followed by a randomized phase with shifting
// push/pop bias so the stack regularly reaches both full and empty.
// -----------------------------------------------------------------------------
module tb_stack_param;

  localparam int W   = 10;
  localparam int D   = 16;
  localparam int INC = 1;
  localparam int CW  = $clog2(D) + 1;
  localparam int MASK = (1 << W) - 1;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          clear  = 1'b0;
  logic          push   = 1'b0;
  logic          pop    = 1'b0;
  logic [W-1:0]  inpush = '0;

  logic [W-1:0]  outpop;
  logic          pop_valid;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  stack_param #(.WIDTH(W), .DEPTH(D), .POP_INC(INC)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .i_push     (push),
    .i_pop      (pop),
    .i_inpush   (inpush),
    .o_outpop   (outpop),
    .o_pop_valid(pop_valid),
    .o_top      (top),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int q[$];
  int m_out = 0;
  bit m_pv  = 1'b0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_top();
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, " count"},     32'(count),     32'(q.size()));
    check({tag, " empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, " full"},      32'(full),      32'(q.size() == D));
    check({tag, " top"},       32'(top),       32'(m_top()));
    check({tag, " outpop"},    32'(outpop),    32'(m_out));
    check({tag, " pop_valid"}, 32'(pop_valid), 32'(m_pv));
    check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_out = 0;
    m_pv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // LIFO behaviour straight from the operation rules
  task automatic model_step(input bit c, input bit pu, input bit po, input int d);
    m_pv = 1'b0;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (pu && po) begin
      if (q.size() > 0) begin
        m_out = (q[q.size()-1] + INC) & MASK;
        m_pv  = 1'b1;
        q[q.size()-1] = d;
      end else begin
        q.push_back(d);
        m_udf = 1'b1;
      end
    end else if (pu) begin
      if (q.size() < D) q.push_back(d);
      else              m_ovf = 1'b1;
    end else if (po) begin
      if (q.size() > 0) begin
        m_out = (q.pop_back() + INC) & MASK;
        m_pv  = 1'b1;
      end else begin
        m_udf = 1'b1;
      end
    end
  endtask

  task automatic do_op(input bit c, input bit pu, input bit po, input int d, input string tag);
    @(negedge clk);
    clear  = c;
    push   = pu;
    pop    = po;
    inpush = W'(d);
    @(posedge clk);
    model_step(c, pu, po, d & MASK);
    #1;
    check_all(tag);
    $display("op %s clr=%0b push=%0b pop=%0b din=%03h -> count=%0d top=%03h outpop=%03h pv=%0b ovf=%0b udf=%0b",
             tag, c, pu, po, d & MASK, count, top, outpop, pop_valid, overflow, underflow);
  endtask

  task automatic idle();
    @(negedge clk);
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  int word15;
  int bias;

  initial begin
    // reset entry and held-reset behaviour
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    push = 1'b1; pop = 1'b1; clear = 1'b0; inpush = W'(10'h155);
    @(posedge clk); #1;
    check_all("ops_in_reset");
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b1;

    // three pushes, three pops
    do_op(0, 1, 0, 'h005, "p3_push");
    do_op(0, 1, 0, 'h006, "p3_push");
    do_op(0, 1, 0, 'h007, "p3_push");
    do_op(0, 0, 1, 0,     "p3_pop");
    check("p3_first_pop", 32'(outpop), 32'h008);
    do_op(0, 0, 1, 0,     "p3_pop");
    do_op(0, 0, 1, 0,     "p3_pop");
    check("p3_last_pop", 32'(outpop), 32'h006);
    do_op(0, 0, 0, 0,     "p3_idle");

    // fill to DEPTH, overflow push, then pop the real top
    for (int i = 0; i < D; i++) do_op(0, 1, 0, $urandom_range(0, MASK), "fill");
    word15 = q[D-1];
    do_op(0, 1, 0, 'h3FF, "ovf_push");
    do_op(0, 0, 1, 0,     "ovf_pop");
    check("ovf_pop_value", 32'(outpop), 32'((word15 + 1) & MASK));

    // underflow then push
    do_op(1, 0, 0, 0,     "clear");
    do_op(0, 0, 1, 0,     "udf_pop");
    do_op(0, 1, 0, 'h010, "udf_push");
    do_op(0, 1, 1, 'h011, "pp_replace");
    do_op(1, 0, 0, 0,     "clear");
    do_op(0, 1, 1, 'h012, "pp_empty");

    // push+pop replacement and increment wrap
    do_op(1, 0, 0, 0,     "clear");
    do_op(0, 1, 0, 'h020, "pp_seed");
    do_op(0, 1, 1, 'h030, "pp");
    check("pp_outpop", 32'(outpop), 32'h021);
    do_op(0, 1, 0, 'h3FF, "wrap_push");
    do_op(0, 0, 1, 0,     "wrap_pop");
    check("wrap_outpop", 32'(outpop), 32'h000);

    // async reset mid-cycle with four entries
    do_op(1, 0, 0, 0, "clear");
    for (int i = 0; i < 4; i++) do_op(0, 1, 0, 'h100 + i, "pre_rst");
    @(negedge clk);
    clear = 1'b0; push = 1'b1; pop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    push = 1'b0;
    rst_n = 1'b1;
    do_op(0, 0, 1, 0, "post_rst_pop");

    // both flags set, then clear keeps outpop
    do_op(0, 1, 0, 'h2AA, "flag_push");
    do_op(0, 0, 1, 0,     "flag_pop");
    for (int i = 0; i < D + 1; i++) do_op(0, 1, 0, i, "flag_fill");
    do_op(1, 0, 0, 0,     "flag_clear");

    // randomized phase
    for (int blk = 0; blk < 8; blk++) begin
      bias = (blk % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 60; i++) begin
        do_op($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < bias,
              $urandom_range(0, 99) < (100 - bias),
              $urandom_range(0, MASK), "rand");
      end
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_param.md
STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 2).
REQ-003 SHALL have parameter POP_INC, default 1, constant added to popped word.
REQ-004 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have clear  input  1  synchronous flush of stack and error flags.
REQ-007 SHALL have push  input  1  write inpush onto stack this cycle.
REQ-008 SHALL have pop  input  1  remove top entry this cycle.
REQ-009 SHALL have inpush  input  WIDTH  data to push.
REQ-010 SHALL have outpop  output  WIDTH  registered popped value plus POP_INC.
REQ-011 SHALL have pop_valid  output  1  registered one-cycle pulse, outpop updated.
REQ-012 SHALL have top  output  WIDTH  combinational current top entry; 0 when empty.
REQ-013 SHALL have count  output  log2(DEPTH)+1  registered number of valid entries.
REQ-014 SHALL have full, empty  output  1 each  combinational from count (count==DEPTH, count==0).
REQ-015 SHALL have overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL use priority per edge: clear > push/pop; clear sets count=0, overflow=0, underflow=0, pop_valid=0, outpop held.
REQ-017 push only, not full: SHALL write inpush at index count, count+1.
REQ-018 push only, full: SHALL drop write, count unchanged, set overflow.
REQ-019 pop only, not empty: SHALL load outpop = (entry[count-1] + POP_INC) mod 2^WIDTH, pulse pop_valid, count-1.
REQ-020 pop only, empty: SHALL hold outpop, pop_valid=0, count stays 0, set underflow.
REQ-021 push+pop, not empty (incl. full): SHALL output old top + POP_INC with pop_valid=1, overwrite entry[count-1] with inpush, count unchanged, no overflow.
REQ-022 push+pop, empty: SHALL perform push only (count=1), set underflow, pop_valid=0.
REQ-023 pop_valid SHALL be 0 in every cycle without a successful pop.
REQ-024 Read latency SHALL be one cycle: outpop/pop_valid valid the cycle after the pop edge.
REQ-025 Overflow/underflow SHALL stay set until clear or reset; they SHALL NOT block later legal operations.
REQ-026 count SHALL never exceed DEPTH nor wrap below 0; index arithmetic uses log2(DEPTH) bits.
REQ-027 top SHALL reflect a push or pop on the same edge count updates.
REQ-028 Storage array contents SHALL NOT be reset; only pointers/flags/outputs reset.

Reset
REQ-029 While reset=0: count=0, empty=1, full=0, outpop=0, pop_valid=0, overflow=0, underflow=0, top=0, asynchronously.
REQ-030 Push/pop/clear asserted during reset SHALL have no effect; first operation takes effect on first rising edge with reset=1.
REQ-031 Reset asserted mid-sequence SHALL discard all entries; subsequent pop on empty sets underflow.

Verification
REQ-032 Push 0x005,0x006,0x007 then 3 pops -> outpop 0x008,0x007,0x006 with pop_valid pulses, count 3->0, empty=1.
REQ-033 Push DEPTH words then one more push (0x3FF) -> full=1, overflow=1, count=DEPTH, following pop returns word DEPTH-1 + 1, not 0x3FF+1.
REQ-034 Pop on empty, then push 0x010 -> underflow=1 persists, pop_valid=0 first cycle, count=1, top=0x010.
REQ-035 Stack holding 0x020, push+pop with inpush=0x030 -> outpop=0x021, pop_valid=1, count unchanged, top=0x030; push 0x3FF then pop -> outpop=0x000 (wrap).
REQ-036 Fill 4 entries, assert reset=0 asynchronously mid-cycle -> all outputs to reset values immediately; after release, pop -> underflow=1, pop_valid=0.
REQ-037 Set overflow and underflow, pulse clear -> count=0, both flags 0, outpop unchanged.
